// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encodings, chirp periods
// and a small helper for sizing the delay counter.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_EXIT_DLY  = 3'd1,
    ST_ARMED     = 3'd2,
    ST_ENTRY_DLY = 3'd3,
    ST_ALARM     = 3'd4
  } state_e;

  localparam int unsigned CHIRP_EXIT_TICKS  = 500;
  localparam int unsigned CHIRP_ENTRY_TICKS = 125;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/motion_debounce.sv
// Motion input conditioning: 2-FF synchronizer followed by a tick-based filter
// that asserts only after DEB_MS consecutive high ticks.
module motion_debounce #(
  parameter int unsigned DEB_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clr,
  input  logic motion_raw,
  output logic motion
);

  localparam int unsigned CNT_W = (DEB_MS > 0) ? $clog2(DEB_MS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEB_MS);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any low synchronized sample restarts the filter; the count saturates.
  always_comb begin
    sync_d = {sync_q[0], motion_raw};
    cnt_d  = cnt_q;
    if (clr || !sync_q[1]) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != CNT_FULL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign motion = (cnt_q == CNT_FULL);

endmodule

// File: rtl/alarm_ctrl.sv
// Burglar-alarm controller: button sync/edge detect, 1 ms tick, delay FSM.
// Define ALARM_CTRL_CHIRP_EN to make the buzzer chirp during exit/entry delays.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned EXIT_MS  = 10000,
  parameter int unsigned ENTRY_MS = 5000,
  parameter int unsigned ALARM_MS = 60000,
  parameter int unsigned DEB_MS   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm_req,
  input  logic       disarm_req,
  input  logic       motion_detected,
  output logic       buzzer,
  output logic       armed_led,
  output logic [2:0] state_o
);

  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAX_DLY = max3(EXIT_MS, ENTRY_MS, ALARM_MS);
  localparam int unsigned DLY_W   = $clog2(MAX_DLY + 1);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [DLY_W-1:0]  EXIT_LAST  = DLY_W'(EXIT_MS - 1);
  localparam logic [DLY_W-1:0]  ENTRY_LAST = DLY_W'(ENTRY_MS - 1);
  localparam logic [DLY_W-1:0]  ALARM_LAST = DLY_W'(ALARM_MS - 1);

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   delay_cnt_q, delay_cnt_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [1:0]         arm_sync_q, arm_sync_d;
  logic [1:0]         disarm_sync_q, disarm_sync_d;
  logic               arm_prev_q, arm_prev_d;
  logic               disarm_prev_q, disarm_prev_d;
  logic               buzzer_q, buzzer_d;
  logic               armed_led_q, armed_led_d;
  logic               tick, arm_rise, disarm_rise, motion, deb_clr;

`ifdef ALARM_CTRL_CHIRP_EN
  localparam int unsigned CHIRP_W = $clog2(CHIRP_EXIT_TICKS + 1);
  logic [CHIRP_W-1:0] chirp_cnt_q, chirp_cnt_d;
  logic [CHIRP_W-1:0] chirp_last;
`endif

  motion_debounce #(
    .DEB_MS(DEB_MS)
  ) u_motion_debounce (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .clr       (deb_clr),
    .motion_raw(motion_detected),
    .motion    (motion)
  );

  assign tick        = (tick_cnt_q == TICK_LAST);
  assign arm_rise    = arm_sync_q[1] & ~arm_prev_q;
  assign disarm_rise = disarm_sync_q[1] & ~disarm_prev_q;

  always_comb begin
    tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
    arm_sync_d    = {arm_sync_q[0], arm_req};
    disarm_sync_d = {disarm_sync_q[0], disarm_req};
    arm_prev_d    = arm_sync_q[1];
    disarm_prev_d = disarm_sync_q[1];
    state_d       = state_q;
    delay_cnt_d   = delay_cnt_q;
    deb_clr       = 1'b0;

    // Timer expiry is checked before motion, so expiry wins a tie.
    case (state_q)
      ST_DISARMED: begin
        if (arm_rise) begin
          state_d     = ST_EXIT_DLY;
          delay_cnt_d = '0;
        end
      end
      ST_EXIT_DLY: begin
        if (tick) begin
          if (delay_cnt_q == EXIT_LAST) begin
            state_d     = ST_ARMED;
            delay_cnt_d = '0;
          end else begin
            delay_cnt_d = delay_cnt_q + 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (motion) begin
          state_d     = ST_ENTRY_DLY;
          delay_cnt_d = '0;
        end
      end
      ST_ENTRY_DLY: begin
        if (tick) begin
          if (delay_cnt_q == ENTRY_LAST) begin
            state_d     = ST_ALARM;
            delay_cnt_d = '0;
          end else begin
            delay_cnt_d = delay_cnt_q + 1'b1;
          end
        end
      end
      ST_ALARM: begin
        if (tick) begin
          if (delay_cnt_q == ALARM_LAST) begin
            state_d     = ST_ARMED;
            delay_cnt_d = '0;
            deb_clr     = 1'b1;
          end else begin
            delay_cnt_d = delay_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_DISARMED;
        delay_cnt_d = '0;
      end
    endcase

    if (disarm_rise && (state_q != ST_DISARMED)) begin
      state_d     = ST_DISARMED;
      delay_cnt_d = '0;
    end

    armed_led_d = (state_d != ST_DISARMED);

`ifdef ALARM_CTRL_CHIRP_EN
    chirp_last  = (state_q == ST_EXIT_DLY) ? CHIRP_W'(CHIRP_EXIT_TICKS - 1)
                                           : CHIRP_W'(CHIRP_ENTRY_TICKS - 1);
    chirp_cnt_d = chirp_cnt_q;
    buzzer_d    = (state_d == ST_ALARM);
    if ((state_d == ST_EXIT_DLY) || (state_d == ST_ENTRY_DLY)) begin
      if (state_d != state_q) begin
        buzzer_d    = 1'b1;
        chirp_cnt_d = '0;
      end else begin
        buzzer_d = buzzer_q;
        if (tick) begin
          if (chirp_cnt_q == chirp_last) begin
            buzzer_d    = ~buzzer_q;
            chirp_cnt_d = '0;
          end else begin
            chirp_cnt_d = chirp_cnt_q + 1'b1;
          end
        end
      end
    end
`else
    buzzer_d = (state_d == ST_ALARM);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_DISARMED;
      delay_cnt_q   <= '0;
      tick_cnt_q    <= '0;
      arm_sync_q    <= '0;
      disarm_sync_q <= '0;
      arm_prev_q    <= 1'b0;
      disarm_prev_q <= 1'b0;
      buzzer_q      <= 1'b0;
      armed_led_q   <= 1'b0;
`ifdef ALARM_CTRL_CHIRP_EN
      chirp_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      delay_cnt_q   <= delay_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      arm_sync_q    <= arm_sync_d;
      disarm_sync_q <= disarm_sync_d;
      arm_prev_q    <= arm_prev_d;
      disarm_prev_q <= disarm_prev_d;
      buzzer_q      <= buzzer_d;
      armed_led_q   <= armed_led_d;
`ifdef ALARM_CTRL_CHIRP_EN
      chirp_cnt_q   <= chirp_cnt_d;
`endif
    end
  end

  assign buzzer    = buzzer_q;
  assign armed_led = armed_led_q;
  assign state_o   = state_q;

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk cycles per 1 ms tick (50 MHz clk).
REQ-002 SHALL have parameter EXIT_MS, default 10000, exit-delay length in ticks.
REQ-003 SHALL have parameter ENTRY_MS, default 5000, entry-delay length in ticks.
REQ-004 SHALL have parameter ALARM_MS, default 60000, alarm duration in ticks.
REQ-005 SHALL have parameter DEB_MS, default 20, motion debounce length in ticks.
REQ-006 SHALL have port clk  input  1  system clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port arm_req  input  1  raw arm button, asynchronous.
REQ-009 SHALL have port disarm_req  input  1  raw disarm button, asynchronous.
REQ-010 SHALL have port motion_detected  input  1  raw PIR output, asynchronous.
REQ-011 SHALL have port buzzer  output  1  buzzer drive, registered.
REQ-012 SHALL have port armed_led  output  1  high in EXIT_DLY, ARMED, ENTRY_DLY, ALARM.
REQ-013 SHALL have port state_o  output  3  current state encoding.

Function
REQ-014 SHALL pass each raw input through a 2-FF synchronizer.
REQ-015 SHALL act on arm/disarm only at rising edges of the synchronized signal, one action per edge.
REQ-016 SHALL generate a 1-cycle tick every TICK_DIV clk cycles from a free-running counter.
REQ-017 SHALL assert internal motion only after the synchronized input has been high for DEB_MS consecutive ticks; any low sample clears the debounce count.
REQ-018 SHALL implement states DISARMED=0, EXIT_DLY=1, ARMED=2, ENTRY_DLY=3, ALARM=4; codes 5-7 SHALL return to DISARMED on the next clk.
REQ-019 DISARMED: arm edge -> EXIT_DLY, delay counter cleared.
REQ-020 EXIT_DLY: motion ignored; after EXIT_MS ticks -> ARMED.
REQ-021 ARMED: debounced motion -> ENTRY_DLY, delay counter cleared.
REQ-022 ENTRY_DLY: after ENTRY_MS ticks -> ALARM.
REQ-023 ALARM: buzzer high continuously; after ALARM_MS ticks -> ARMED (re-arm, debounce count cleared).
REQ-024 Disarm edge in any non-DISARMED state -> DISARMED, buzzer low next cycle; disarm SHALL win over simultaneous arm, motion or timer expiry.
REQ-025 Arm edges outside DISARMED SHALL be ignored.
REQ-026 Timer expiry and motion in the same cycle SHALL follow the expiry transition only.
REQ-027 State change SHALL occur on the clk edge after the qualifying event; input-to-state latency for buttons is 3 clk cycles (2 sync + 1 edge register).
REQ-028 Delay counter SHALL be wide enough for the largest of EXIT_MS, ENTRY_MS, ALARM_MS and SHALL not wrap.

Reset
REQ-029 reset low SHALL asynchronously force: state DISARMED, buzzer 0, armed_led 0, state_o 0, all counters and synchronizers 0.
REQ-030 Deassertion SHALL take effect at the next clk edge; reset mid-ALARM silences the buzzer immediately.

Configuration
REQ-031 With ALARM_CTRL_CHIRP_EN defined, buzzer SHALL toggle every 500 ticks in EXIT_DLY and every 125 ticks in ENTRY_DLY, starting high on state entry.
REQ-032 Without ALARM_CTRL_CHIRP_EN, buzzer SHALL be high only in ALARM.

Structure
REQ-033 State encodings and chirp periods SHALL live in shared package alarm_pkg.
REQ-034 Debounce/synchronizer SHALL be sub-module motion_debounce (sync + DEB_MS filter), instantiated once.

Verification (TICK_DIV=4, EXIT_MS=10, ENTRY_MS=5, ALARM_MS=20, DEB_MS=2)
REQ-035 Reset low 100 ns then high; no inputs -> state_o=0, buzzer=0 for 500 cycles.
REQ-036 Arm pulse -> state_o=1 after 3 cycles, state_o=2 after 40 further cycles; motion during EXIT_DLY ignored.
REQ-037 ARMED, motion high 8 cycles -> state_o=3; 20 cycles later state_o=4, buzzer=1; 80 cycles later state_o=2, buzzer=0.
REQ-038 Motion glitch of 4 cycles in ARMED -> state_o stays 2.
REQ-039 In ALARM, disarm and arm pulsed together -> state_o=0, buzzer=0 within 4 cycles.
REQ-040 Reset low during ALARM -> buzzer=0 and state_o=0 before next clk edge.
